// File: rtl/even_parity_serial_checker.sv
// Serial even-parity frame checker: DATA_W data bits (LSB first) then a parity bit,
// presented on a valid/ready output. Define PARITY_ERR_CNT_EN to build the error counter.
//
// state | meaning
// IDLE  | waiting for data bit 0
// SHIFT | collecting data bits 1..DATA_W-1 and the parity bit
// DONE  | frame presented on out_valid, input stalled
module even_parity_serial_checker #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W:0]   frame_out,
  output logic              parity_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (DATA_W + 1 > 2) ? $clog2(DATA_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W:0]  shreg;
  logic [DATA_W:0]  frame_asm;
  logic             accept;
  logic             complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (cnt == LAST_POS)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign complete = accept && (state == SHIFT) && (cnt == LAST_POS);

  // Assembled frame including the bit arriving this cycle, so the parity bit
  // lands directly in frame_out on the completing edge.
  always_comb begin
    frame_asm      = shreg;
    frame_asm[cnt] = in_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      frame_out  <= '0;
      parity_err <= 1'b0;
    end else if (accept) begin
      shreg <= frame_asm;
      if (complete) begin
        cnt        <= '0;
        frame_out  <= frame_asm;
        parity_err <= ^frame_asm;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign data_out = frame_out[DATA_W-1:0];

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (complete && (^frame_asm) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_even_parity_serial_checker.sv
// Randomized self-checking bench for even_parity_serial_checker (DATA_W=3) against
// a frame-level parity model; honours PARITY_ERR_CNT_EN for the error counter.
module tb_even_parity_serial_checker;

  localparam int DATA_W = 3;
  localparam int FW     = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, parity_err, busy;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W:0]   frame_out;
  logic [7:0]        err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  even_parity_serial_checker #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .frame_out(frame_out), .parity_err(parity_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is in error when it carries an odd number of ones.
  function automatic logic ref_err(input logic [FW-1:0] f);
    return ($countones(f) % 2) != 0;
  endfunction

  function automatic void model_frame(input logic [FW-1:0] f);
`ifdef PARITY_ERR_CNT_EN
    if (ref_err(f) && exp_cnt < 255) exp_cnt = exp_cnt + 1;
`endif
  endfunction

  task automatic send_frame(input logic [FW-1:0] f, input int gap);
    for (int i = 0; i < FW; i++) begin
      in_valid = 1'b1;
      in_bit   = f[i];
      tick();
      in_valid = 1'b0;
      if (i != FW - 1) for (int g = 0; g < gap; g++) tick();
    end
    model_frame(f);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
    checks++; if (frame_out !== 4'b0000 || data_out !== 3'b000 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_data got frame=%b data=%b perr=%b exp 0", frame_out, data_out, parity_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
  endtask

  task automatic test_good_frames();
    logic [FW-1:0] fr [2];
    fr[0] = 4'b0000;
    fr[1] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      send_frame(fr[k], 0);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL good_valid[%0d] got vld=%b rdy=%b exp 1 0", k, out_valid, in_ready); end
      checks++; if (frame_out !== fr[k] || data_out !== fr[k][DATA_W-1:0]) begin errors++; $display("FAIL good_frame[%0d] got %b/%b exp %b", k, frame_out, data_out, fr[k]); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL good_perr[%0d] got %b exp 0", k, parity_err); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL good_release[%0d] got vld=%b rdy=%b exp 0 1", k, out_valid, in_ready); end
    end
  endtask

  task automatic test_errored_frame();
    send_frame(4'b1101, 0);
    checks++; if (frame_out !== 4'b1101 || data_out !== 3'b101) begin errors++; $display("FAIL err_frame got %b/%b exp 1101/101", frame_out, data_out); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL err_perr got %b exp 1", parity_err); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL err_count got %0d exp %0d", err_count, exp_cnt); end
    handshake();
  endtask

  task automatic test_random_frames();
    logic [FW-1:0] f;
    int stall;
    for (int k = 0; k < 40; k++) begin
      f = FW'($urandom);
      send_frame(f, int'($urandom_range(0, 2)));
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) tick();
      checks++; if (out_valid !== 1'b1 || frame_out !== f || data_out !== f[DATA_W-1:0] || parity_err !== ref_err(f)) begin errors++; $display("FAIL rand[%0d] got vld=%b frame=%b perr=%b exp 1 %b %b", k, out_valid, frame_out, parity_err, f, ref_err(f)); end
      checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", k, err_count, exp_cnt); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f;
    f = 4'b1010;
    send_frame(f, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_bit   = c[0];
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || frame_out !== f || parity_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got rdy=%b vld=%b frame=%b perr=%b exp 0 1 %b 0", c, in_ready, out_valid, frame_out, parity_err, f); end
    end
    // in_valid still high during the handshake: that bit must not be taken.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy); end
    checks++; if (frame_out !== f) begin errors++; $display("FAIL bp_after got %b exp %b", frame_out, f); end
  endtask

  task automatic test_gaps();
    logic [FW-1:0] f;
    f = 4'b1010;
    for (int i = 0; i < FW; i++) begin
      in_valid = 1'b1;
      in_bit   = f[i];
      tick();
      in_valid = 1'b0;
      if (i != FW - 1) begin
        tick();
        tick();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL gap_mid[%0d] got busy=%b vld=%b rdy=%b exp 1 0 1", i, busy, out_valid, in_ready); end
      end
    end
    model_frame(f);
    checks++; if (out_valid !== 1'b1 || data_out !== 3'b010 || parity_err !== 1'b0) begin errors++; $display("FAIL gap_frame got vld=%b data=%b perr=%b exp 1 010 0", out_valid, data_out, parity_err); end
    handshake();
  endtask

  task automatic test_abort();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre got busy=%b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL abort_async got busy=%b rdy=%b vld=%b cnt=%0d exp 0 1 0 0", busy, in_ready, out_valid, err_count); end
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    send_frame(4'b0110, 0);
    checks++; if (out_valid !== 1'b1 || frame_out !== 4'b0110 || parity_err !== 1'b0) begin errors++; $display("FAIL abort_next got vld=%b frame=%b perr=%b exp 1 0110 0", out_valid, frame_out, parity_err); end
    handshake();
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_saturation();
    logic [FW-1:0] f;
    for (int k = 0; k < 260; k++) begin
      f[DATA_W-1:0] = DATA_W'($urandom);
      f[DATA_W]     = ~(^f[DATA_W-1:0]);
      send_frame(f, 0);
      if (k == 254 || k == 259) begin
        checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, err_count, exp_cnt); end
      end
      handshake();
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frames();
    test_errored_frame();
    test_random_frames();
    test_backpressure();
    test_gaps();
    test_abort();
`ifdef PARITY_ERR_CNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/even_parity_serial_checker.md
# even_parity_serial_checker

Receive-side counterpart to the even parity generator. The block accepts a serial frame of `DATA_W` data bits followed by one even-parity bit. It reassembles the frame and checks the parity. It then presents the recovered data, the full frame and an error flag on a valid/ready output handshake. It sits at the far end of a link driven by the parity generator's `{parity_bit, A}` word, serialised LSB first.

## Interface
- `DATA_W`, default 3: number of data bits per frame; frame length is `DATA_W+1`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_bit` carries a frame bit this cycle.
- `in_bit`  in  1  serial bit; data bit 0 first, parity bit last.
- `in_ready`  out  1  block can accept a bit.
- `out_valid`  out  1  completed frame is presented.
- `out_ready`  in  1  downstream accepts the presented frame.
- `data_out`  out  `DATA_W`  recovered data `A`.
- `frame_out`  out  `DATA_W+1`  `{parity, data}`, the generator's `Out` word.
- `parity_err`  out  1  frame failed even parity; qualified by `out_valid`.
- `busy`  out  1  a frame is partially received.
- `err_count`  out  8  count of errored frames.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:**
  - `in_ready`=1 and `busy`=0.
  - An accepted bit (`in_valid & in_ready`) is stored as bit 0 and the bit counter is set to 1.
  - The state then moves to SHIFT.
- **SHIFT:**
  - `in_ready`=1 and `busy`=1.
  - Each accepted bit is stored at the position given by the counter, and the counter increments.
  - When the accepted bit has counter == `DATA_W` (the parity bit), the frame is complete and the state moves to DONE.
  - Cycles with `in_valid`=0 hold all state. There is no timeout.
- **Entering DONE:**
  - `frame_out` is loaded with the assembled `DATA_W+1` bits.
  - `data_out` = `frame_out[DATA_W-1:0]`.
  - `parity_err` = XOR-reduce of all `DATA_W+1` bits. A nonzero result means an odd count of ones, which is an error.
- **DONE:**
  - `out_valid`=1, `in_ready`=0 and `busy`=0.
  - `in_bit` is ignored, even when `in_valid` is high.
  - `data_out`, `frame_out` and `parity_err` are stable while `out_valid` is held.
  - When `out_valid & out_ready` at a clock edge, the state returns to IDLE.
- **Output registers:**
  - `data_out`, `frame_out` and `parity_err` hold their values after the handshake until the next frame completes.
  - They are don't-care whenever `out_valid`=0.
- **Bit counter:** width is `$clog2(DATA_W+1)` (1 bit minimum). It is reset to 0 in IDLE, so there is no wrap-around.
- **`DATA_W` range:** 1 to 32.

## Timing
- **Reset values:**
  - state IDLE, counter 0.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `data_out`=0, `frame_out`=0, `parity_err`=0, `err_count`=0.
- **Reset mid-frame:** on `rst` assertion the block returns immediately (asynchronously) to the reset values. The partial frame is discarded and not counted.
- **Latency:** `out_valid` rises on the clock edge that accepts the parity bit. It is visible in the cycle after the bit was presented.
- **Throughput:** at least one bubble per frame.
  - `in_ready` is 0 for every cycle spent in DONE.
  - `in_ready` returns to 1 the cycle after the output handshake.
  - Best case is `DATA_W+2` cycles per frame.
- **Simultaneous `in_valid` and `out_ready` in DONE:** the output handshake completes and the bit is not consumed. The sender must re-present the bit, since `in_ready` was 0.
- `out_ready` is ignored outside DONE.

## Configuration
- **`PARITY_ERR_CNT_EN` defined:**
  - `err_count` is an 8-bit counter.
  - It increments by 1 on the edge entering DONE with `parity_err`=1.
  - It saturates at 255 and clears only on `rst`.
- **`PARITY_ERR_CNT_EN` undefined:**
  - No counter logic is built and `err_count` is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
- **Reset check:** assert `rst` then release, with `DATA_W`=3.
  - All outputs hold their reset values.
  - `in_ready`=1.
- **Good frames:** send bits 0,0,0,0 (data 000, parity 0).
  - `out_valid`=1, `data_out`=3'b000, `frame_out`=4'b0000, `parity_err`=0.
  - Then send 1,1,0,0: `data_out`=3'b011, `frame_out`=4'b0011, `parity_err`=0.
- **Errored frame:** send 1,0,1,1 (data 101, parity 1).
  - `frame_out`=4'b1101, `parity_err`=1.
  - `err_count`=1 with the macro defined, 0 without it.
- **Backpressure:** complete a frame, hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `in_bit` toggling.
  - `in_ready`=0 throughout and outputs stay stable.
  - Then pulse `out_ready` for 1 cycle: `out_valid` falls and `in_ready`=1 on the next cycle.
- **Gaps and abort:**
  - Insert `in_valid`=0 gaps between every bit of frame 0,1,0,1: result is data 010, `parity_err`=0.
  - Separately, assert `rst` after 2 bits: `busy`=0 immediately and the next 4 bits form a clean new frame.
- **Saturation:** with the macro defined, send 260 errored frames.
  - `err_count` reaches 255 and stays at 255.
